spi_cmd_decoder: RTL

- Sits directly downstream of the breakout SPI slave interface. Consumes each received 16-bit word (write_value qualified by the one-cycle write_en pulse) and the start_transaction pulse.
- Decodes each word into game control registers: paddle position and run/reset control.
- Decodes brick-row writes, which leave through a 2-entry FIFO with a valid/ready handshake to the brick memory.
- Keeps sticky overflow and saturating illegal-command status for readback via the SPI state vector.

---
 rtl/spi_cmd_decoder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/spi_cmd_decoder.sv
// SPI command decoder for the breakout game.
// Turns each received 16-bit SPI word into game control register updates.
// Brick-row writes are queued in a 2-entry FIFO for the brick memory.
// Sticky overflow, illegal-command and per-transaction word counters are
// kept for readback.
module spi_cmd_decoder #(
    parameter int         ROWS       = 8,
    parameter int         ROW_W      = 12,
    parameter logic [9:0] PADDLE_MAX = 10'd600
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      write_value,
    input  logic             write_en,
    input  logic             start_transaction,
    output logic [9:0]       paddle_x,
    output logic             run,
    output logic             game_reset,
    output logic             brick_valid,
    output logic [3:0]       brick_row,
    output logic [ROW_W-1:0] brick_bits,
    input  logic             brick_ready,
    output logic             ovf,
    output logic [7:0]       err_cnt,
    output logic [7:0]       word_cnt
);

    localparam int         ENT_W    = 4 + ROW_W;
    localparam logic [4:0] ROWS_LIM = 5'(ROWS);
    localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

    // Control and status registers
    logic [9:0] paddle_q, paddle_d;
    logic       run_q, run_d;
    logic       game_reset_q, game_reset_d;
    logic       ovf_q, ovf_d;
    logic [7:0] err_q, err_d;
    logic [7:0] word_q, word_d;
    logic [3:0] row_ptr_q, row_ptr_d;

    // FIFO storage: two slots addressed by 1-bit read/write pointers
    logic [ENT_W-1:0] fifo_q [2];
    logic             rd_ptr_q, wr_ptr_q;
    logic [1:0]       count_q, count_d;

    // Decode helpers
    logic [3:0]       cmd;
    logic [11:0]      arg;
    logic [3:0]       ptr_base;
    logic             push, pop, drop, illegal, ovf_clr, fifo_full;
    logic [ENT_W-1:0] push_entry;

    assign brick_valid = (count_q != 2'd0);
    assign brick_row   = fifo_q[rd_ptr_q][ENT_W-1:ROW_W];
    assign brick_bits  = fifo_q[rd_ptr_q][ROW_W-1:0];
    assign paddle_x    = paddle_q;
    assign run         = run_q;
    assign game_reset  = game_reset_q;
    assign ovf         = ovf_q;
    assign err_cnt     = err_q;
    assign word_cnt    = word_q;

    // Decode the incoming word and compute next register/FIFO state.
    // start_transaction is folded in first so a coincident word sees row_ptr=0.
    always_comb begin
        cmd          = write_value[15:12];
        arg          = write_value[11:0];
        ptr_base     = start_transaction ? 4'd0 : row_ptr_q;
        row_ptr_d    = ptr_base;
        paddle_d     = paddle_q;
        run_d        = run_q;
        game_reset_d = 1'b0;
        ovf_d        = ovf_q;
        err_d        = err_q;
        push         = 1'b0;
        drop         = 1'b0;
        illegal      = 1'b0;
        ovf_clr      = 1'b0;
        pop          = brick_valid & brick_ready;
        fifo_full    = (count_q == 2'd2) && !pop;
        push_entry   = {ptr_base, arg[ROW_W-1:0]};

        word_d = start_transaction ? 8'd0 : word_q;
        if (write_en && word_d != 8'hFF) begin
            word_d = word_d + 8'd1;
        end

        if (write_en) begin
            case (cmd)
                4'h0: begin
                end
                4'h1: paddle_d = (arg[9:0] > PADDLE_MAX) ? PADDLE_MAX : arg[9:0];
                4'h2: begin
                    run_d        = arg[0];
                    game_reset_d = arg[1];
                    ovf_clr      = arg[2];
                end
                4'h3: begin
                    if ({1'b0, arg[3:0]} < ROWS_LIM) begin
                        row_ptr_d = arg[3:0];
                    end else begin
                        illegal = 1'b1;
                    end
                end
                4'h4: begin
                    if (!fifo_full) begin
                        push      = 1'b1;
                        row_ptr_d = (ptr_base == LAST_ROW) ? 4'd0 : ptr_base + 4'd1;
                    end else begin
                        drop = 1'b1;
                    end
                end
                default: illegal = 1'b1;
            endcase
        end

        // A drop in the same cycle as a clear leaves ovf set
        if (ovf_clr) ovf_d = 1'b0;
        if (drop)    ovf_d = 1'b1;

        if (illegal && err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
        end

        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    // Register update; reset discards FIFO contents and all status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            paddle_q     <= '0;
            run_q        <= 1'b0;
            game_reset_q <= 1'b0;
            ovf_q        <= 1'b0;
            err_q        <= '0;
            word_q       <= '0;
            row_ptr_q    <= '0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            count_q      <= '0;
            fifo_q[0]    <= '0;
            fifo_q[1]    <= '0;
        end else begin
            paddle_q     <= paddle_d;
            run_q        <= run_d;
            game_reset_q <= game_reset_d;
            ovf_q        <= ovf_d;
            err_q        <= err_d;
            word_q       <= word_d;
            row_ptr_q    <= row_ptr_d;
            count_q      <= count_d;
            // When full with a pop, the write slot equals the slot being freed
            if (push) begin
                fifo_q[wr_ptr_q] <= push_entry;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

endmodule
